// File: rtl/pe_cfg_ctrl.sv
// rtl/pe_cfg_ctrl.sv - per-PE config shadow/commit controller with 2-entry output FIFO
module pe_cfg_ctrl #(
  parameter int PEID       = 0,
  parameter int ID_W       = 8,
  parameter int FIELD_W    = 13,
  parameter int NUM_FIELDS = 8,
  parameter int DATA_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ID_W-1:0]               id,
  input  logic [ID_W-1:0]               id_mask,
  input  logic                          broadcast,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [FIELD_W-1:0]            cfg_data,
  input  logic                          cfg_last,
  input  logic                          commit,
  input  logic                          core_idle,
  output logic [NUM_FIELDS*FIELD_W-1:0] cfg_flat,
  output logic                          cfg_pending,
  output logic                          cfg_err,
  output logic                          active,
  input  logic                          core_dout_valid,
  output logic                          core_dout_ready,
  input  logic [DATA_W-1:0]             core_dout_data,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [DATA_W-1:0]             dout_data
);

  localparam int                 IDX_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [FIELD_W-1:0] HOLD     = {2'b10, {(FIELD_W-2){1'b0}}};
  localparam logic [ID_W-1:0]    PEID_V   = ID_W'(PEID);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_FIELDS-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_APPLY} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [FIELD_W-1:0]   r_shadow [NUM_FIELDS];
  logic [FIELD_W-1:0]   r_live   [NUM_FIELDS];
  logic [IDX_W-1:0]     r_idx;
  logic                 r_err;
  logic [DATA_W-1:0]    r_fifo   [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  logic w_active;
  logic w_accept;
  logic w_commit;
  logic w_at_end;
  logic w_apply;
  logic w_set_err;
  logic w_push;
  logic w_pop;

  // A PE is addressed when broadcast, or when every non-masked id bit matches PEID
  assign w_active  = broadcast | (((id ^ PEID_V) & ~id_mask) == '0);
  assign active    = w_active;

  assign cfg_ready = w_active && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_commit  = commit && w_active;
  assign w_at_end  = (r_idx == LAST_IDX);

  assign cfg_pending = (r_state == S_FULL) || (r_state == S_APPLY);
  assign cfg_err     = r_err;

  genvar g;
  for (g = 0; g < NUM_FIELDS; g++) begin : g_flat
    assign cfg_flat[g*FIELD_W +: FIELD_W] = r_live[g];
  end

  // Next-state, apply strobe and error strobe for the load/commit sequence
  always_comb begin
    w_state_next = r_state;
    w_apply      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (cfg_last || w_at_end) w_state_next = S_FULL;
          else                      w_state_next = S_LOAD;
          // Overrunning the last slot without cfg_last is flagged; idx never wraps
          if (w_at_end && !cfg_last) w_set_err = 1'b1;
        end
        // Commit before the shadow set is complete is dropped and flagged
        if (w_commit) w_set_err = 1'b1;
      end
      S_FULL: begin
        if (w_commit) begin
          if (core_idle) begin
            w_apply      = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        // Commit already latched; just wait for the core to go idle
        if (core_idle) begin
          w_apply      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Shadow load, live update on apply, field index and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        r_shadow[k] <= HOLD;
        r_live[k]   <= '0;
      end
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_set_err) r_err <= 1'b1;
      if (w_accept) begin
        r_shadow[r_idx] <= cfg_data;
        if (!(cfg_last || w_at_end)) r_idx <= r_idx + 1'b1;
      end
      if (w_apply) begin
        for (int k = 0; k < NUM_FIELDS; k++) begin
          // Fields still carrying the hold code leave the live value untouched
          if (r_shadow[k][FIELD_W-1 -: 2] != 2'b10) r_live[k] <= r_shadow[k];
          r_shadow[k] <= HOLD;
        end
        r_idx <= '0;
      end
    end
  end

  assign core_dout_ready = (r_count != 2'd2);
  assign dout_valid      = (r_count != 2'd0) && w_active;
  assign w_push          = core_dout_valid && core_dout_ready;
  assign w_pop           = dout_valid && dout_ready;
  assign dout_data       = r_fifo[r_rd_ptr];

  // Two-entry in-order output FIFO; simultaneous push and pop keep the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= core_dout_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_cfg_ctrl.sv
// tb/tb_pe_cfg_ctrl.sv - randomized self-checking bench for pe_cfg_ctrl
module tb_pe_cfg_ctrl;

  localparam int PEID    = 3;
  localparam int ID_W    = 8;
  localparam int FIELD_W = 13;
  localparam int NF      = 8;
  localparam int DATA_W  = 16;
  localparam logic [FIELD_W-1:0] HOLD = 13'h1000;

  logic                     clk;
  logic                     rst_n;
  logic [ID_W-1:0]          id;
  logic [ID_W-1:0]          id_mask;
  logic                     broadcast;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [FIELD_W-1:0]       cfg_data;
  logic                     cfg_last;
  logic                     commit;
  logic                     core_idle;
  logic [NF*FIELD_W-1:0]    cfg_flat;
  logic                     cfg_pending;
  logic                     cfg_err;
  logic                     active;
  logic                     core_dout_valid;
  logic                     core_dout_ready;
  logic [DATA_W-1:0]        core_dout_data;
  logic                     dout_valid;
  logic                     dout_ready;
  logic [DATA_W-1:0]        dout_data;

  pe_cfg_ctrl #(
    .PEID(PEID), .ID_W(ID_W), .FIELD_W(FIELD_W), .NUM_FIELDS(NF), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .id_mask(id_mask), .broadcast(broadcast),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .commit(commit), .core_idle(core_idle), .cfg_flat(cfg_flat), .cfg_pending(cfg_pending),
    .cfg_err(cfg_err), .active(active), .core_dout_valid(core_dout_valid),
    .core_dout_ready(core_dout_ready), .core_dout_data(core_dout_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: shadow/live arrays, load progress flags, FIFO as a queue
  logic [FIELD_W-1:0] m_live [NF];
  logic [FIELD_W-1:0] m_sh   [NF];
  int                 m_widx;
  bit                 m_full;
  bit                 m_wait;
  bit                 m_err;
  logic [DATA_W-1:0]  m_q [$];
  bit                 m_ok = 1'b0;

  string        pin_name;
  logic [127:0] pin_act;
  logic [127:0] pin_exp;
  int           pin_seq  = 0;
  int           pin_done = 0;

  function automatic bit act_fn(logic [ID_W-1:0] i, logic [ID_W-1:0] m, logic b);
    return b || (((i ^ ID_W'(PEID)) & ~m) == '0);
  endfunction

  function automatic logic [FIELD_W-1:0] rnd_field();
    logic [FIELD_W-1:0] d;
    d = FIELD_W'($urandom);
    if (d[FIELD_W-1 -: 2] == 2'b10) d = ($urandom_range(1) == 1) ? HOLD : {1'b0, d[FIELD_W-2:0]};
    return d;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit        md_a, md_full, md_wait, md_apply, md_push, md_pop;
  int        md_n;
  always @(posedge clk) begin
    md_a = act_fn(id, id_mask, broadcast);
    if (!rst_n) begin
      for (int k = 0; k < NF; k++) begin
        m_live[k] = '0;
        m_sh[k]   = HOLD;
      end
      m_widx = 0; m_full = 0; m_wait = 0; m_err = 0;
      m_q.delete();
      m_ok = 1'b1;
    end else if (m_ok) begin
      md_full  = m_full;
      md_wait  = m_wait;
      md_apply = 1'b0;
      if (cfg_valid && md_a && !md_full && !md_wait) begin
        m_sh[m_widx] = cfg_data;
        if (cfg_last || m_widx == NF-1) begin
          m_full = 1'b1;
          if (!cfg_last) m_err = 1'b1;
        end else begin
          m_widx++;
        end
      end
      if (md_wait) begin
        if (core_idle) md_apply = 1'b1;
      end else if (md_full) begin
        if (commit && md_a) begin
          if (core_idle) md_apply = 1'b1;
          else begin m_full = 1'b0; m_wait = 1'b1; end
        end
      end else if (commit && md_a) begin
        m_err = 1'b1;
      end
      if (md_apply) begin
        for (int k = 0; k < NF; k++) begin
          if (m_sh[k][FIELD_W-1 -: 2] != 2'b10) m_live[k] = m_sh[k];
          m_sh[k] = HOLD;
        end
        m_widx = 0; m_full = 0; m_wait = 0;
      end
      md_n    = m_q.size();
      md_push = core_dout_valid && (md_n < 2);
      md_pop  = md_a && (md_n > 0) && dout_ready;
      if (md_pop)  void'(m_q.pop_front());
      if (md_push) m_q.push_back(core_dout_data);
    end
  end

  bit                    cm_a, cm_v;
  logic [NF*FIELD_W-1:0] cm_flat;
  always @(negedge clk) begin
    if (m_ok) begin
      cm_a = act_fn(id, id_mask, broadcast);
      for (int k = 0; k < NF; k++) cm_flat[k*FIELD_W +: FIELD_W] = m_live[k];
      cm_v = (m_q.size() > 0) && cm_a;
      chk("active", 128'(active), 128'(cm_a));
      chk("cfg_ready", 128'(cfg_ready), 128'(cm_a && !m_full && !m_wait));
      chk("cfg_pending", 128'(cfg_pending), 128'(m_full || m_wait));
      chk("cfg_err", 128'(cfg_err), 128'(m_err));
      chk("cfg_flat", 128'(cfg_flat), 128'(cm_flat));
      chk("core_dout_ready", 128'(core_dout_ready), 128'(m_q.size() < 2));
      chk("dout_valid", 128'(dout_valid), 128'(cm_v));
      if (cm_v) chk("dout_data", 128'(dout_data), 128'(m_q[0]));
    end
    if (pin_seq != pin_done) begin
      chk(pin_name, pin_act, pin_exp);
      pin_done = pin_seq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [127:0] a, input logic [127:0] e);
    pin_name = nm;
    pin_act  = a;
    pin_exp  = e;
    pin_seq++;
    @(negedge clk);
    #1;
  endtask

  logic [NF*FIELD_W-1:0] e_flat;
  logic [DATA_W-1:0]     rx [$];
  int                    sent;
  int                    cyc;

  initial begin
    rst_n = 0; id = 8'd3; id_mask = '0; broadcast = 0;
    cfg_valid = 0; cfg_data = '0; cfg_last = 0; commit = 0; core_idle = 1;
    core_dout_valid = 0; core_dout_data = '0; dout_ready = 0;
    step(); step();
    pin("reset_outputs", 128'({cfg_flat, cfg_pending, cfg_ready, dout_valid, core_dout_ready, cfg_err}),
        128'({104'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}));
    rst_n = 1;
    step();

    for (int i = 1; i <= 8; i++) begin
      cfg_valid = 1; cfg_data = FIELD_W'(i); cfg_last = (i == 8);
      step();
    end
    cfg_valid = 0; cfg_last = 0; commit = 1; core_idle = 1;
    step();
    commit = 0;
    for (int k = 0; k < NF; k++) e_flat[k*FIELD_W +: FIELD_W] = FIELD_W'(k+1);
    #1;
    pin("full_load_commit", 128'({cfg_flat, cfg_pending}), 128'({e_flat, 1'b0}));

    step();
    id = 8'd5; id_mask = '0; broadcast = 0; cfg_valid = 1; cfg_data = 13'h0011;
    #1;
    pin("unaddressed_ready", 128'(cfg_ready), 128'(0));
    step();
    broadcast = 1;
    #1;
    pin("broadcast_ready", 128'(cfg_ready), 128'(1));
    step();
    broadcast = 0; id = 8'd3; cfg_data = HOLD;
    step();
    cfg_data = 13'h0033; cfg_last = 1;
    step();
    cfg_valid = 0; cfg_last = 0; commit = 1;
    step();
    commit = 0;
    e_flat[0*FIELD_W +: FIELD_W] = 13'h0011;
    e_flat[2*FIELD_W +: FIELD_W] = 13'h0033;
    #1;
    pin("hold_partial_commit", 128'(cfg_flat), 128'(e_flat));

    step();
    cfg_valid = 1; cfg_data = 13'h0100; cfg_last = 1;
    step();
    cfg_valid = 0; cfg_last = 0; commit = 1; core_idle = 0;
    repeat (4) step();
    pin("apply_wait", 128'({cfg_pending, cfg_flat[FIELD_W-1:0]}), 128'({1'b1, 13'h0011}));
    commit = 0; core_idle = 1;
    step();
    #1;
    pin("apply_done", 128'({cfg_pending, cfg_flat[FIELD_W-1:0], cfg_err}), 128'({1'b0, 13'h0100, 1'b0}));

    step();
    sent = 0; cyc = 0;
    while ((sent < 6 || rx.size() < 6) && cyc < 40) begin
      core_dout_valid = (sent < 6);
      core_dout_data  = DATA_W'(16'hA0 + sent);
      dout_ready      = (cyc % 2 == 0);
      #2;
      if (core_dout_valid && core_dout_ready) sent++;
      if (dout_valid && dout_ready) rx.push_back(dout_data);
      @(posedge clk);
      #1;
      cyc++;
    end
    core_dout_valid = 0; dout_ready = 0;
    pin("fifo_count", 128'(rx.size()), 128'(6));
    for (int i = 0; i < rx.size(); i++) pin("fifo_order", 128'(rx[i]), 128'(16'hA0 + i));

    step();
    cfg_valid = 1; cfg_data = 13'h0007;
    step(); step();
    cfg_valid = 0; commit = 1;
    step();
    commit = 0;
    #1;
    pin("commit_in_load_err", 128'(cfg_err), 128'(1));
    step(); step();
    pin("err_sticky", 128'(cfg_err), 128'(1));
    cfg_valid = 1; cfg_data = 13'h0009;
    step();
    cfg_valid = 0; rst_n = 0;
    step();
    #1;
    pin("reset_mid_load", 128'({cfg_flat, cfg_err, cfg_pending, cfg_ready}), 128'({104'h0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1;
    step();

    for (int i = 0; i < NF; i++) begin
      cfg_valid = 1; cfg_data = FIELD_W'(16'h20 + i); cfg_last = 0;
      step();
    end
    cfg_valid = 0;
    #1;
    pin("overrun_err", 128'({cfg_err, cfg_pending}), 128'(2'b11));
    commit = 1; core_idle = 1;
    step();
    commit = 0;
    for (int k = 0; k < NF; k++) e_flat[k*FIELD_W +: FIELD_W] = FIELD_W'(16'h20 + k);
    #1;
    pin("overrun_apply", 128'(cfg_flat), 128'(e_flat));
    rst_n = 0;
    step();
    rst_n = 1;

    for (int c = 0; c < 3000; c++) begin
      rst_n           = ($urandom_range(199) != 0);
      id              = ($urandom_range(3) == 0) ? ID_W'($urandom) : ID_W'(PEID);
      id_mask         = ($urandom_range(3) == 0) ? ID_W'($urandom) : '0;
      broadcast       = ($urandom_range(7) == 0);
      cfg_valid       = ($urandom_range(1) == 1);
      cfg_data        = rnd_field();
      cfg_last        = ($urandom_range(4) == 0);
      commit          = ($urandom_range(6) == 0);
      core_idle       = ($urandom_range(4) < 3);
      core_dout_valid = ($urandom_range(1) == 1);
      core_dout_data  = DATA_W'($urandom);
      dout_ready      = ($urandom_range(1) == 1);
      step();
    end
    cfg_valid = 0; commit = 0; core_dout_valid = 0; rst_n = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
